// File: rtl/video_timing.sv
// Raster timing generator with a small CPU register window (status, control, raster, frame counter).
// Latency: counters and flags update on each clk edge; syncs, visible and dout are combinational; irq lags flags by one clk.
// Backpressure: none; the CPU bus is single-cycle with no wait states, and cs=0 leaves all state untouched.
//
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   cs, rw, addr, di    : CPU bus select, 1=write/0=read, register index, write data
//   dout                : read data (0x00 unless cs=1 and rw=0)
//   hpos, vpos          : current pixel column / line
//   hsync, vsync,
//   visible, irq        : active-high timing strobes and interrupt request
//
// Build option: define VIDEO_TIMING_RASTER_IRQ_EN to enable the RASTER compare
// register, the RSF status flag and the RSIE interrupt enable.
module video_timing #(
  parameter int H_VISIBLE = 160,
  parameter int H_FP      = 4,
  parameter int H_SYNC    = 24,
  parameter int H_BP      = 12,
  parameter int V_VISIBLE = 120,
  parameter int V_FP      = 1,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs,
  input  logic       rw,
  input  logic [2:0] addr,
  input  logic [7:0] di,
  output logic [7:0] dout,
  output logic [7:0] hpos,
  output logic [6:0] vpos,
  output logic       hsync,
  output logic       vsync,
  output logic       visible,
  output logic       irq
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  // One extra bit on the compare constants so a sync ending exactly at the
  // last column/line does not truncate to zero.
  localparam logic [8:0] H_VIS9 = 9'(H_VISIBLE);
  localparam logic [8:0] HS_BEG = 9'(H_VISIBLE + H_FP);
  localparam logic [8:0] HS_END = 9'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [7:0] H_LAST = 8'(H_TOTAL - 1);
  localparam logic [7:0] V_VIS8 = 8'(V_VISIBLE);
  localparam logic [7:0] VS_BEG = 8'(V_VISIBLE + V_FP);
  localparam logic [7:0] VS_END = 8'(V_VISIBLE + V_FP + V_SYNC);
  localparam logic [6:0] V_VIS7 = 7'(V_VISIBLE);
  localparam logic [6:0] V_LAST = 7'(V_TOTAL - 1);

  logic        h_wrap;
  logic [7:0]  hpos_nxt;
  logic [6:0]  vpos_nxt;
  logic        vblank_evt;
  logic        live;
  logic        wr_en;
  logic        rd_en;
  logic        vbf;
  logic        vbie;
  logic        rsf;
  logic        rsie;
  logic [6:0]  raster;
  logic [15:0] frame;
  logic [7:0]  frame_hi;
  logic [7:0]  rd_val;
  logic        unused_di;

  assign h_wrap   = (hpos == H_LAST);
  assign hpos_nxt = h_wrap ? 8'd0 : hpos + 8'd1;
  assign vpos_nxt = !h_wrap          ? vpos :
                    (vpos == V_LAST) ? 7'd0 : vpos + 7'd1;

  // Edge on which the counters land on (0, V_VISIBLE): start of vertical blank.
  assign vblank_evt = h_wrap && (vpos_nxt == V_VIS7);

  assign hsync   = ({1'b0, hpos} >= HS_BEG) && ({1'b0, hpos} < HS_END);
  assign vsync   = ({1'b0, vpos} >= VS_BEG) && ({1'b0, vpos} < VS_END);
  assign visible = ({1'b0, hpos} < H_VIS9) && ({1'b0, vpos} < V_VIS8);
  assign live    = ({1'b0, vpos} >= V_VIS8);

  assign wr_en = cs & rw;
  assign rd_en = cs & ~rw;

  // Data bits that no register keeps.
  assign unused_di = ^di[7:2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hpos     <= 8'd0;
      vpos     <= 7'd0;
      vbf      <= 1'b0;
      vbie     <= 1'b0;
      frame    <= 16'd0;
      frame_hi <= 8'd0;
      irq      <= 1'b0;
    end else begin
      hpos <= hpos_nxt;
      vpos <= vpos_nxt;
      // Set has priority over a same-edge write-1-to-clear.
      if (vblank_evt)
        vbf <= 1'b1;
      else if (wr_en && addr == 3'd0 && di[0])
        vbf <= 1'b0;
      if (wr_en && addr == 3'd1)
        vbie <= di[0];
      if (vblank_evt)
        frame <= frame + 16'd1;
      // Reading the low byte freezes the high byte so a 16-bit read is coherent.
      if (rd_en && addr == 3'd4)
        frame_hi <= frame[15:8];
      irq <= (vbf & vbie) | (rsf & rsie);
    end
  end

`ifdef VIDEO_TIMING_RASTER_IRQ_EN
  logic raster_evt;
  assign raster_evt = h_wrap && (vpos_nxt == raster);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsf    <= 1'b0;
      rsie   <= 1'b0;
      raster <= 7'd0;
    end else begin
      if (raster_evt)
        rsf <= 1'b1;
      else if (wr_en && addr == 3'd0 && di[1])
        rsf <= 1'b0;
      if (wr_en && addr == 3'd1)
        rsie <= di[1];
      if (wr_en && addr == 3'd2)
        raster <= di[6:0];
    end
  end
`else
  assign rsf    = 1'b0;
  assign rsie   = 1'b0;
  assign raster = 7'd0;
`endif

  always_comb begin
    rd_val = 8'h00;
    case (addr)
      3'd0:    rd_val = {live, 5'b00000, rsf, vbf};
      3'd1:    rd_val = {6'b000000, rsie, vbie};
      3'd2:    rd_val = {1'b0, raster};
      3'd3:    rd_val = {1'b0, vpos};
      3'd4:    rd_val = frame[7:0];
      3'd5:    rd_val = frame_hi;
      default: rd_val = 8'h00;
    endcase
  end

  assign dout = rd_en ? rd_val : 8'h00;

endmodule

// File: doc/video_timing.md
VIDEO_TIMING -- requirements
Module: video_timing

Interface
REQ-001 SHALL have parameter H_VISIBLE, default 160: visible pixels per line.
REQ-002 SHALL have parameter H_FP, H_SYNC, H_BP, defaults 4, 24, 12: horizontal front porch, sync and back porch in clocks; H_TOTAL = sum = 200, and H_TOTAL SHALL be 256 or less.
REQ-003 SHALL have parameter V_VISIBLE, default 120: visible lines per frame.
REQ-004 SHALL have parameter V_FP, V_SYNC, V_BP, defaults 1, 2, 3: vertical porches and sync in lines; V_TOTAL = 126, and V_TOTAL SHALL be 128 or less.
REQ-005 SHALL have port clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port cs, input, 1 bit: CPU-bus register select.
REQ-008 SHALL have port rw, input, 1 bit: 1 = write, 0 = read.
REQ-009 SHALL have port addr, input, 3 bits: register index.
REQ-010 SHALL have port di, input, 8 bits: write data.
REQ-011 SHALL have port dout, output, 8 bits: read data.
REQ-012 SHALL have ports hpos (output, 8 bits) and vpos (output, 7 bits): current pixel position.
REQ-013 SHALL have ports hsync, vsync, visible and irq: outputs, 1 bit each, all active-high.

Function
REQ-014 hpos SHALL increment every clk, wrap H_TOTAL-1 -> 0, and on that wrap vpos SHALL increment, wrapping V_TOTAL-1 -> 0.
REQ-015 hsync SHALL be 1 iff H_VISIBLE+H_FP <= hpos < H_VISIBLE+H_FP+H_SYNC, decoded combinationally from the registered counters.
REQ-016 vsync SHALL be 1 iff V_VISIBLE+V_FP <= vpos < V_VISIBLE+V_FP+V_SYNC, decoded combinationally from the registered counters.
REQ-017 visible SHALL be 1 iff hpos < H_VISIBLE and vpos < V_VISIBLE.
REQ-018 "vblank start" is defined as the counters transitioning to hpos=0, vpos=V_VISIBLE. At that edge the STATUS.VBF flag SHALL set and the 16-bit frame counter SHALL increment, wrapping 0xFFFF -> 0x0000.
REQ-019 Register map, addressed by addr:
- 0 STATUS: bit0 VBF, bit1 RSF, bit7 live (vpos >= V_VISIBLE), other bits 0. Writing 1 to bit0 or bit1 clears that flag (write-1-to-clear).
- 1 CTRL: bit0 VBIE, bit1 RSIE; read/write; other bits read 0.
- 2 RASTER: 7-bit compare line, read/write; bit7 reads 0.
- 3 VPOS: read-only; returns {0, vpos}.
- 4 FRAME_LO: read-only.
- 5 FRAME_HI: returns the latched high byte.
- 6 and 7: read 0x00; writes ignored.
REQ-020 dout SHALL be the combinational register value when cs=1 and rw=0, and 0x00 otherwise.
REQ-021 A read of FRAME_LO (cs=1, rw=0, addr=4 at a clk edge) SHALL copy frame[15:8] into the FRAME_HI latch on that edge.
REQ-022 RSF SHALL set on the edge where the counters become hpos=0 and vpos=RASTER.
REQ-023 If a flag's set event and its write-1-to-clear occur on the same edge, set SHALL win.
REQ-024 irq SHALL be registered as irq = (VBF and VBIE) or (RSF and RSIE), one clk after the flag or enable change.
REQ-025 Writes SHALL take effect only on a clk edge with cs=1 and rw=1; cs=0 SHALL cause no side effects.

Reset
REQ-026 While reset=1, the block SHALL hold hpos=0, vpos=0, hsync=0, vsync=0, visible=1, irq=0, and all registers, flags, frame counter and latch at 0, asynchronously and mid-line included.
REQ-027 Counting SHALL resume from hpos=0, vpos=0 on the first clk edge after reset deasserts.

Configuration
REQ-028 Macro VIDEO_TIMING_RASTER_IRQ_EN: when defined, the RASTER register, RSF and RSIE SHALL behave as specified above.
REQ-029 When VIDEO_TIMING_RASTER_IRQ_EN is undefined, RASTER SHALL read 0x00 and ignore writes, STATUS bit1 and CTRL bit1 SHALL read 0, and irq = VBF and VBIE.

Verification
REQ-030 Free-run after reset for 200*126 clks -> hsync high exactly for hpos 164..187; vsync high exactly for vpos 121..122; counters return to (0,0).
REQ-031 Write CTRL=0x01, run to vblank start -> VBF=1, irq=1 one clk later; write STATUS=0x01 -> VBF=0 and irq drops.
REQ-032 Write RASTER=0x10 and CTRL=0x02 -> RSF sets when hpos=0, vpos=16; irq=1 on the next edge; with the macro undefined, irq stays 0.
REQ-033 Preload the frame counter to 0x00FF by running 255 frames, then read FRAME_LO=0xFF and FRAME_HI=0x00; after the next vblank, FRAME_HI stays 0x00 until FRAME_LO is re-read, which returns 0x00 and latches 0x01.
REQ-034 Issue a STATUS=0x01 write on the vblank-start edge -> VBF=1 (set wins).
REQ-035 Assert reset at hpos=100, vpos=50 -> all outputs take their reset values immediately, without waiting for clk.
